// File: rtl/stolen_cdc_rst_sequencer_if.sv
// Handshake bundle between the reset sequencer and the per-domain reset fabric.
// The sequencer uses the master modport; the fabric/bench uses the slave modport.
interface stolen_cdc_rst_sequencer_if #(
   parameter int N_DOM = 4
);
   localparam int ERR_W = $clog2(N_DOM);

   logic             sw_rst_req;
   logic [N_DOM-1:0] dom_ack_i;
   logic [N_DOM-1:0] dom_rst_o;
   logic             seq_busy;
   logic             seq_done;
   logic             timeout_err;
   logic [ERR_W-1:0] err_dom;

   modport master (
      input  sw_rst_req,
      input  dom_ack_i,
      output dom_rst_o,
      output seq_busy,
      output seq_done,
      output timeout_err,
      output err_dom
   );

   modport slave (
      output sw_rst_req,
      output dom_ack_i,
      input  dom_rst_o,
      input  seq_busy,
      input  seq_done,
      input  timeout_err,
      input  err_dom
   );
endinterface

// File: rtl/stolen_cdc_rst_sequencer.sv
// Reset sequencer: holds all clock domains in reset, then releases them one by one
// in index order, waiting on each domain's synchronized ack with a bounded timeout.
module stolen_cdc_rst_sequencer #(
   parameter int N_DOM       = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                            clk,
   input  logic                            rst_n,
   stolen_cdc_rst_sequencer_if.master      bus
);
   localparam int ERR_W  = $clog2(N_DOM);
   localparam int MAX_C  = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
   localparam int CNT_W  = $clog2(MAX_C + 1);

   typedef enum logic [1:0] {
      HOLD        = 2'd0,
      WAIT_ASSERT = 2'd1,
      REL_WAIT    = 2'd2,
      DONE        = 2'd3
   } state_t;

   state_t           r_state,   w_state;
   logic [CNT_W-1:0] r_cnt,     w_cnt;
   logic [ERR_W-1:0] r_idx,     w_idx;
   logic [N_DOM-1:0] r_dom_rst, w_dom_rst;
   logic             r_busy,    w_busy;
   logic             r_done,    w_done;
   logic             r_terr,    w_terr;
   logic [ERR_W-1:0] r_err,     w_err;
   logic [ERR_W-1:0] w_ack_zero;
   logic             w_timeout;
   logic             w_all_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= HOLD;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_dom_rst <= '1;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
         r_terr    <= 1'b0;
         r_err     <= '0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_idx     <= w_idx;
         r_dom_rst <= w_dom_rst;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_terr    <= w_terr;
         r_err     <= w_err;
      end
   end

   // The release of the next domain is decided on the same edge that sees the
   // previous ack, so each release lands exactly one cycle after its trigger.
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt + CNT_W'(1);
      w_idx      = r_idx;
      w_dom_rst  = r_dom_rst;
      w_done     = r_done;
      w_terr     = r_terr;
      w_err      = r_err;
      w_ack_zero = '0;
      w_all_ack  = &bus.dom_ack_i;
      w_timeout  = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));

      for (int i = N_DOM - 1; i >= 0; i--) begin
         if (!bus.dom_ack_i[i]) w_ack_zero = ERR_W'(i);
      end

      case (r_state)
         HOLD: begin
            w_dom_rst = '1;
            if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
               w_state = WAIT_ASSERT;
               w_cnt   = '0;
            end
         end
         WAIT_ASSERT: begin
            if (w_all_ack || w_timeout) begin
               if (!w_all_ack) begin
                  w_terr = 1'b1;
                  if (!r_terr) w_err = w_ack_zero;
               end
               w_dom_rst[0] = 1'b0;
               w_idx        = '0;
               w_state      = REL_WAIT;
               w_cnt        = '0;
            end
         end
         REL_WAIT: begin
            if (!bus.dom_ack_i[r_idx] || w_timeout) begin
               if (bus.dom_ack_i[r_idx]) begin
                  w_terr = 1'b1;
                  if (!r_terr) w_err = r_idx;
               end
               if (r_idx == ERR_W'(N_DOM - 1)) begin
                  w_state   = DONE;
                  w_dom_rst = '0;
                  w_done    = 1'b1;
               end else begin
                  w_dom_rst[r_idx + ERR_W'(1)] = 1'b0;
                  w_idx                        = r_idx + ERR_W'(1);
               end
               w_cnt = '0;
            end
         end
         DONE: begin
            w_cnt     = '0;
            w_dom_rst = '0;
            if (bus.sw_rst_req) begin
               w_state   = HOLD;
               w_dom_rst = '1;
               w_done    = 1'b0;
               w_terr    = 1'b0;
               w_err     = '0;
               w_idx     = '0;
            end
         end
         default: begin
            w_state = HOLD;
            w_cnt   = '0;
         end
      endcase

      w_busy = ~w_done;
   end

   assign bus.dom_rst_o   = r_dom_rst;
   assign bus.seq_busy    = r_busy;
   assign bus.seq_done    = r_done;
   assign bus.timeout_err = r_terr;
   assign bus.err_dom     = r_err;
endmodule

// File: tb/tb_stolen_cdc_rst_sequencer.sv
// Directed bench for the reset sequencer: acks are dom_rst_o looped back through a
// 4-flop delay, with per-bit force masks to model stuck domains.
module tb_stolen_cdc_rst_sequencer;
   localparam int N_DOM = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic [3:0] forceOne  = 4'b0000;
   logic [3:0] forceZero = 4'b0000;
   logic [3:0] dly0 = 4'b1111;
   logic [3:0] dly1 = 4'b1111;
   logic [3:0] dly2 = 4'b1111;
   logic [3:0] dly3 = 4'b1111;
   int edgeNo = 0;
   int errCount = 0;
   int checkCount = 0;

   typedef struct {
      int         edgeN;
      logic [3:0] rst;
      logic       busy;
      logic       done;
      logic       terr;
      logic [1:0] err;
   } vec_t;

   vec_t cleanTab[12];

   stolen_cdc_rst_sequencer_if #(.N_DOM(N_DOM)) bus ();

   stolen_cdc_rst_sequencer #(
      .N_DOM(N_DOM),
      .HOLD_CYCLES(16),
      .ACK_TIMEOUT(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Models the per-domain synchronizer round trip as a fixed 4-cycle delay.
   always @(posedge clk) begin
      dly0 <= bus.dom_rst_o;
      dly1 <= dly0;
      dly2 <= dly1;
      dly3 <= dly2;
   end

   assign bus.dom_ack_i = (dly3 | forceOne) & ~forceZero;

   function automatic logic [8:0] snap();
      return {bus.dom_rst_o, bus.seq_busy, bus.seq_done, bus.timeout_err, bus.err_dom};
   endfunction

   function automatic logic [8:0] pack(logic [3:0] r, logic b, logic d, logic t, logic [1:0] e);
      return {r, b, d, t, e};
   endfunction

   task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got rst/busy/done/terr/err=%b expected %b", name, act, exp);
      end
   endtask

   task automatic goToEdge(input int n);
      while (edgeNo < n) begin
         @(posedge clk);
         #1;
         edgeNo++;
      end
   endtask

   task automatic applyStimulus(input logic [3:0] fOne, input logic [3:0] fZero);
      forceOne  = fOne;
      forceZero = fZero;
      rst_n     = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      edgeNo = 0;
   endtask

   task automatic runTable(input string tag);
      for (int i = 0; i < 12; i++) begin
         goToEdge(cleanTab[i].edgeN);
         checkOutput($sformatf("%s[%0d]@%0d", tag, i, cleanTab[i].edgeN), snap(),
                     pack(cleanTab[i].rst, cleanTab[i].busy, cleanTab[i].done,
                          cleanTab[i].terr, cleanTab[i].err));
      end
   endtask

   initial begin
      cleanTab[0]  = '{1,  4'b1111, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[1]  = '{16, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[2]  = '{17, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[3]  = '{21, 4'b1110, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[4]  = '{22, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[5]  = '{26, 4'b1100, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[6]  = '{27, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[7]  = '{31, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[8]  = '{32, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[9]  = '{36, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0};
      cleanTab[10] = '{37, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
      cleanTab[11] = '{45, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};

      bus.sw_rst_req = 1'b0;

      // Power-up: async reset asserted before the first clock edge.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("por_async", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      repeat (5) @(posedge clk);
      #1;
      checkOutput("por_held", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      rst_n  = 1'b1;
      edgeNo = 0;
      $display("[TB] clean power-up sequence");
      runTable("clean");

      // A request outside DONE must be dropped, not queued.
      $display("[TB] ignored sw_rst_req during REL_WAIT(1)");
      applyStimulus(4'b0000, 4'b0000);
      goToEdge(23);
      bus.sw_rst_req = 1'b1;
      goToEdge(24);
      bus.sw_rst_req = 1'b0;
      checkOutput("ign_e24", snap(), pack(4'b1100, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(27);
      checkOutput("ign_e27", snap(), pack(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(37);
      checkOutput("ign_done", snap(), pack(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
      goToEdge(40);
      checkOutput("ign_stay", snap(), pack(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));

      $display("[TB] stuck release on domain 2");
      applyStimulus(4'b0100, 4'b0000);
      goToEdge(27);
      checkOutput("srel_e27", snap(), pack(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(90);
      checkOutput("srel_e90", snap(), pack(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(91);
      checkOutput("srel_to", snap(), pack(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2));
      goToEdge(95);
      checkOutput("srel_e95", snap(), pack(4'b0000, 1'b1, 1'b0, 1'b1, 2'd2));
      goToEdge(96);
      checkOutput("srel_done", snap(), pack(4'b0000, 1'b0, 1'b1, 1'b1, 2'd2));

      $display("[TB] software rerun from DONE with sticky error");
      forceOne = 4'b0000;
      goToEdge(100);
      bus.sw_rst_req = 1'b1;
      edgeNo = -1;
      goToEdge(0);
      bus.sw_rst_req = 1'b0;
      checkOutput("rerun_e0", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      runTable("rerun");

      // Domain 1 never asserts; domain 3 never releases. First error index must stick.
      $display("[TB] stuck assert on domain 1 plus stuck release on domain 3");
      applyStimulus(4'b1000, 4'b0010);
      goToEdge(16);
      checkOutput("sas_e16", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(79);
      checkOutput("sas_e79", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      goToEdge(80);
      checkOutput("sas_to", snap(), pack(4'b1110, 1'b1, 1'b0, 1'b1, 2'd1));
      goToEdge(85);
      checkOutput("sas_e85", snap(), pack(4'b1100, 1'b1, 1'b0, 1'b1, 2'd1));
      goToEdge(86);
      checkOutput("sas_e86", snap(), pack(4'b1000, 1'b1, 1'b0, 1'b1, 2'd1));
      goToEdge(91);
      checkOutput("sas_e91", snap(), pack(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1));
      goToEdge(154);
      checkOutput("sas_e154", snap(), pack(4'b0000, 1'b1, 1'b0, 1'b1, 2'd1));
      goToEdge(155);
      checkOutput("sas_done", snap(), pack(4'b0000, 1'b0, 1'b1, 1'b1, 2'd1));

      $display("[TB] asynchronous reset mid-sequence in REL_WAIT(2)");
      applyStimulus(4'b0000, 4'b0000);
      goToEdge(28);
      checkOutput("mid_e28", snap(), pack(4'b1000, 1'b1, 1'b0, 1'b0, 2'd0));
      #3 rst_n = 1'b0;
      #1;
      checkOutput("mid_async", snap(), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
      repeat (5) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      edgeNo = 0;
      runTable("mid");

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end
endmodule
